bit_serial_adder: RTL and testbench

//  - Multi-bit adder that adds two WIDTH-bit operands one bit per clock, LSB first.
//  - Uses a single full-adder cell, built from two half-adder stages, plus a registered carry.
//  - Sits downstream of the half-adder datapath cells.
//  - Serves as the area-minimal adder for control-path arithmetic.
//  - Start/done handshake; result held until the next accepted start.

---
 rtl/bit_serial_pkg.sv | 13 +
 rtl/bit_serial_adder_fa.sv | 21 ++
 rtl/bit_serial_adder.sv | 112 +++++++++++
 tb/tb_bit_serial_adder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/bit_serial_pkg.sv
// Shared constants for the bit-serial adder: state encoding and default width.
package bit_serial_pkg;

  localparam int   DEFAULT_WIDTH = 8;
  localparam logic ST_IDLE       = 1'b0;
  localparam logic ST_SHIFT      = 1'b1;

  typedef enum logic {
    S_IDLE  = ST_IDLE,
    S_SHIFT = ST_SHIFT
  } state_e;

endpackage

// File: rtl/bit_serial_adder_fa.sv
// Single full-adder cell built from two cascaded half-adder stages.
module full_adder_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p1;
  logic g1;
  logic g2;

  // First stage adds the operand bits; second stage folds in the carry.
  assign p1   = a ^ b;
  assign g1   = a & b;
  assign s    = p1 ^ cin;
  assign g2   = p1 & cin;
  assign cout = g1 | g2;

endmodule

// File: rtl/bit_serial_adder.sv
// Serial adder: one sum bit per clock, LSB first, with start/done handshake.
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  // Extra counter bit keeps the count from wrapping within one operation.
  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_q, c_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             carry_q, carry_d;

  logic             fa_s;
  logic             fa_cout;

  full_adder_cell u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (c_q),
    .s    (fa_s),
    .cout (fa_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_d     = c_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    carry_d = carry_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          c_d     = cin;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        sum_d = {fa_s, sum_q[WIDTH-1:1]};
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        c_d   = fa_cout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          carry_d = fa_cout;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed and randomized checks of bit_serial_adder against an arithmetic model.
module tb_bit_serial_adder;

  localparam int W8 = 8;
  localparam int W4 = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start8, cin8, busy8, done8, carry8;
  logic [W8-1:0] a8, b8, sum8;
  logic          start4, cin4, busy4, done4, carry4;
  logic [W4-1:0] a4, b4, sum4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );

  bit_serial_adder #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .carry(carry4)
  );

  // Reference: the plain integer sum; bit w of it is the carry-out.
  function automatic int ref_add(input int a, input int b, input int c);
    return a + b + c;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run8(input logic [W8-1:0] a, input logic [W8-1:0] b, input logic c,
                      input string tag);
    int r;
    int busy_cnt;
    bit seen;
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; cin8 = c;
    @(negedge clk);
    start8 = 1'b0;
    a8 = 8'($urandom_range(255)); b8 = 8'($urandom_range(255)); cin8 = 1'($urandom_range(1));
    busy_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin
        seen = 1'b1;
        break;
      end
      if (busy8) busy_cnt++;
      @(negedge clk);
    end
    r = ref_add(int'(a), int'(b), int'(c));
    chk({tag, "_done_seen"}, 64'(seen), 64'(1));
    chk({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W8));
    chk({tag, "_sum"}, 64'(sum8), 64'(r % 256));
    chk({tag, "_carry"}, 64'(carry8), 64'(r / 256));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done8), 64'(0));
    chk({tag, "_sum_held"}, 64'(sum8), 64'(r % 256));
  endtask

  task automatic run4(input int a, input int b, input int c);
    bit seen;
    @(negedge clk);
    start4 = 1'b1; a4 = 4'(a); b4 = 4'(b); cin4 = 1'(c);
    @(negedge clk);
    start4 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done4) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk($sformatf("exh4_%0d_%0d_%0d", a, b, c), 64'({seen, carry4, sum4}),
        64'({1'b1, 5'(ref_add(a, b, c))}));
  endtask

  initial begin
    int ndone;
    int t1, t2;
    logic [W8-1:0] s1, s2;
    logic c1, c2;

    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({busy8, done8, carry8, sum8}), 64'(0));
    rst = 1'b0;

    run8(8'd3, 8'd5, 1'b0, "basic");
    run8(8'd255, 8'd1, 1'b0, "ovf");
    run8(8'd0, 8'd0, 1'b1, "cin_only");
    run8(8'd255, 8'd255, 1'b1, "max");

    // Start while busy is ignored.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd10; b8 = 8'd20; cin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    start8 = 1'b1; a8 = 8'd1; b8 = 8'd1; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    ndone = 0;
    s1 = '0;
    for (int i = 0; i < 20; i++) begin
      if (done8) begin
        ndone++;
        s1 = sum8;
      end
      @(negedge clk);
    end
    chk("busy_start_ndone", 64'(ndone), 64'(1));
    chk("busy_start_sum", 64'(s1), 64'(30));

    // Reset mid-operation aborts it.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd200; b8 = 8'd100; cin8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_outputs", 64'({busy8, done8, carry8, sum8}), 64'(0));
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done8) ndone++;
      @(negedge clk);
    end
    chk("midrst_no_done", 64'(ndone), 64'(0));
    run8(8'd3, 8'd5, 1'b0, "after_rst");

    // Back-to-back with start held high.
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd100; b8 = 8'd27; cin8 = 1'b0;
    @(negedge clk);
    a8 = 8'd200; b8 = 8'd100;
    ndone = 0;
    t1 = 0; t2 = 0; s1 = '0; s2 = '0; c1 = 1'b0; c2 = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done8) begin
        ndone++;
        if (ndone == 1) begin
          t1 = i; s1 = sum8; c1 = carry8;
        end else begin
          t2 = i; s2 = sum8; c2 = carry8;
          start8 = 1'b0;
          break;
        end
      end
      @(negedge clk);
    end
    start8 = 1'b0;
    chk("b2b_ndone", 64'(ndone), 64'(2));
    chk("b2b_period", 64'(t2 - t1), 64'(W8 + 1));
    chk("b2b_first", 64'({c1, s1}), 64'(ref_add(100, 27, 0)));
    chk("b2b_second", 64'({c2, s2}), 64'(ref_add(200, 100, 0)));
    @(negedge clk);
    @(negedge clk);
    chk("b2b_idle_after", 64'(busy8), 64'(0));

    for (int k = 0; k < 24; k++)
      run8(8'($urandom_range(255)), 8'($urandom_range(255)), 1'($urandom_range(1)), "rand");

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run4(a, b, c);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
